// File: rtl/pullup_mon_pkg.sv
// Shared types and constants for the pulled-up line monitor.
package pullup_mon_pkg;

  // Measurement FSM: waiting for a first edge, or inside a high / low phase.
  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } mon_state_t;

  // Depth of the pad-input synchronizer.
  localparam int unsigned SYNC_STAGES = 2;

endpackage : pullup_mon_pkg

// File: rtl/line_glitch_filter.sv
// Synchronizes the raw pad value and turns it into a glitch-free level with edge pulses.
module line_glitch_filter
  import pullup_mon_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned FCW = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES);
  localparam logic [FCW-1:0] FLIM = FCW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FCW-1:0]         fcnt_q;
  logic                   line_s;
  logic                   differ_c;
  logic                   toggle_c;

  // Plain flop chain; idles high like the pulled-up line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
    end
  end

  assign line_s   = sync_q[SYNC_STAGES-1];
  assign differ_c = (line_s != level);
  // The edge that brings the disagreement count to FILTER_CYCLES flips the level.
  assign toggle_c = differ_c && (fcnt_q == FLIM);
  assign rise_c   = toggle_c && line_s;
  assign fall_c   = toggle_c && !line_s;

  // Disagreement counter, filtered level and registered edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q <= '0;
      level  <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      fcnt_q <= (differ_c && !toggle_c) ? fcnt_q + FCW'(1) : '0;
      level  <= level ^ toggle_c;
      rise   <= rise_c;
      fall   <= fall_c;
    end
  end

endmodule : line_glitch_filter

// File: rtl/pullup_line_monitor.sv
// Receive-side monitor: filtered level, edges, high/low phase lengths and stuck-line flag.
module pullup_line_monitor
  import pullup_mon_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned TIMEOUT       = 'h200000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             line_in,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] high_cycles,
  output logic [CNT_W-1:0] low_cycles,
  output logic             meas_valid,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

  logic             rise_c;
  logic             fall_c;
  logic             edge_c;
  logic             timeout_c;
  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] phase_inc_c;
  mon_state_t       state_q;
  mon_state_t       state_d;
  logic             have_high_q;
  logic             have_high_d;
  logic             latch_high_c;
  logic             latch_low_c;
  logic             meas_c;

  line_glitch_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk    (clk),
    .rst    (rst),
    .line_in(line_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  // The counter is 0 in the edge-pulse cycle, so the phase ending now is phase_q + 1.
  assign edge_c      = rise_c || fall_c;
  assign phase_inc_c = (phase_q == CNT_MAX) ? phase_q : phase_q + CNT_W'(1);
  assign timeout_c   = !edge_c && (phase_inc_c == TMO);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_EDGE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: follow the edge chain, drop back to WAIT_EDGE on timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_EDGE: begin
        if (rise_c)      state_d = HIGH;
        else if (fall_c) state_d = LOW;
      end
      HIGH: begin
        if (fall_c)         state_d = LOW;
        else if (timeout_c) state_d = WAIT_EDGE;
      end
      LOW: begin
        if (rise_c)         state_d = HIGH;
        else if (timeout_c) state_d = WAIT_EDGE;
      end
      default: state_d = WAIT_EDGE;
    endcase
  end

  // Latch enables and measurement-pulse decode; an edge from WAIT_EDGE is never measured.
  always_comb begin
    latch_high_c = 1'b0;
    latch_low_c  = 1'b0;
    meas_c       = 1'b0;
    have_high_d  = have_high_q;
    case (state_q)
      WAIT_EDGE: begin
        have_high_d = 1'b0;
      end
      HIGH: begin
        if (fall_c) begin
          latch_high_c = 1'b1;
          have_high_d  = 1'b1;
        end else if (timeout_c) begin
          have_high_d = 1'b0;
        end
      end
      LOW: begin
        if (rise_c) begin
          latch_low_c = 1'b1;
          meas_c      = have_high_q;
        end else if (timeout_c) begin
          have_high_d = 1'b0;
        end
      end
      default: have_high_d = 1'b0;
    endcase
  end

  // Phase counter, measurement latches, valid pulse and stuck flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= '0;
      high_cycles <= '0;
      low_cycles  <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      have_high_q <= 1'b0;
    end else begin
      phase_q     <= edge_c ? '0 : phase_inc_c;
      meas_valid  <= meas_c;
      have_high_q <= have_high_d;
      if (latch_high_c) high_cycles <= phase_inc_c;
      if (latch_low_c)  low_cycles  <= phase_inc_c;
      if (edge_c)         stuck <= 1'b0;
      else if (timeout_c) stuck <= 1'b1;
    end
  end

endmodule : pullup_line_monitor
